// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one single-cycle memory between an
// instruction-fetch port (read only) and a data port (read/write).
//
// Each transaction takes IDLE/DONE -> ACCESS -> DONE. The winner's port,
// address, write enable and write data are latched on the grant edge. The
// memory is strobed for exactly one cycle in ACCESS. The served port is
// acked in DONE, where the other port may already be granted. This gives
// one transaction per two cycles back to back.
//
// Build option: MEM_ARB_RR_EN
//   Defined:   round-robin between the two ports when both are eligible.
//   Undefined: the data port always beats the instruction port.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   i_req, i_addr     instruction read request and address
//   i_rdata, i_ack    instruction read data and completion pulse
//   d_req, d_we       data request and write enable
//   d_addr, d_wdata   data request address and write data
//   d_rdata, d_ack    data read data and completion pulse
//   mem_addr          shared memory address
//   mem_wdata         shared memory write data
//   mem_rdata         memory read data, valid one cycle after mem_oe
//   mem_st, mem_oe    memory store strobe and output enable
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_st,
  output logic              mem_oe
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;          // 1 = data port, 0 = instruction port
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;  // doubles as the latched address
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;          // 1 = data port was granted last
`endif

  logic elig_i;
  logic elig_d;
  logic grant_d;

  // A port being acked this cycle cannot be granted again in the same cycle.
  assign elig_i = i_req && !(state_q == DONE && !port_q);
  assign elig_d = d_req && !(state_q == DONE && port_q);

`ifdef MEM_ARB_RR_EN
  assign grant_d = elig_d && (!elig_i || !last_q);
`else
  assign grant_d = elig_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    mem_oe      = 1'b0;
    mem_st      = 1'b0;
    i_ack       = 1'b0;
    d_ack       = 1'b0;

    case (state_q)
      ACCESS: begin
        mem_oe  = !we_q;
        mem_st  = we_q;
        state_d = DONE;
      end
      IDLE, DONE: begin
        if (state_q == DONE) begin
          i_ack = !port_q;
          d_ack = port_q;
          if (!we_q) begin
            if (port_q) d_rdata_d = mem_rdata;
            else        i_rdata_d = mem_rdata;
          end
        end
        if (elig_i || elig_d) begin
          state_d    = ACCESS;
          port_d     = grant_d;
          we_d       = grant_d && d_we;
          mem_addr_d = grant_d ? d_addr : i_addr;
          // Write data is only replaced by a write so it holds across reads.
          if (grant_d && d_we) mem_wdata_d = d_wdata;
`ifdef MEM_ARB_RR_EN
          last_d     = grant_d;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Read data is returned straight from memory in the ack cycle and is held
  // by the port register afterwards.
  assign i_rdata = i_ack ? mem_rdata : i_rdata_q;
  assign d_rdata = (d_ack && !we_q) ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_st;
  logic        mem_oe;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_st(mem_st), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and an independent copy kept by the model.
  logic [15:0] env_mem [0:65535];
  logic [15:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_st) env_mem[mem_addr] <= mem_wdata;
    if (mem_oe) mem_rdata <= env_mem[mem_addr];
  end

  // Reference model: one transaction record with the cycle numbers in which
  // its memory access and its ack happen.
  typedef struct {
    bit          valid;
    bit          port;   // 1 = data
    logic [15:0] addr;
    bit          we;
    logic [15:0] wdata;
    int          acc;    // access cycle; ack is the cycle after
  } txn_t;

  txn_t        t;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit          last_d;
  bit          e_iack, e_dack, e_oe, e_st;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    t.valid  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_irdata = '0;
    m_drdata = '0;
    last_d   = 1'b0;
  endtask

  // Predict what the next rising edge does, from the inputs now applied.
  task automatic model_advance();
    bit in_acc, acking, ei, ed, win_d;
    if (!reset) return;
    in_acc = t.valid && (cyc == t.acc);
    acking = t.valid && (cyc == t.acc + 1);
    if (in_acc) begin
      if (t.we)        ref_mem[t.addr] = t.wdata;
      else if (t.port) m_drdata = ref_mem[t.addr];
      else             m_irdata = ref_mem[t.addr];
    end
    if (!in_acc) begin
      ei = i_req && !(acking && !t.port);
      ed = d_req && !(acking && t.port);
      if (ei || ed) begin
        if (ei && ed) begin
`ifdef MEM_ARB_RR_EN
          win_d = !last_d;
`else
          win_d = 1'b1;
`endif
        end else begin
          win_d = ed;
        end
        t.valid = 1'b1;
        t.port  = win_d;
        t.addr  = win_d ? d_addr : i_addr;
        t.we    = win_d && d_we;
        t.wdata = d_wdata;
        t.acc   = cyc + 1;
        m_addr  = t.addr;
        if (t.we) m_wdata = d_wdata;
        last_d  = win_d;
      end
    end
  endtask

  task automatic check_all();
    bit in_acc, acking;
    in_acc = t.valid && (cyc == t.acc);
    acking = t.valid && (cyc == t.acc + 1);
    e_oe   = in_acc && !t.we;
    e_st   = in_acc && t.we;
    e_iack = acking && !t.port;
    e_dack = acking && t.port;
    check_eq("i_ack", i_ack, e_iack);
    check_eq("d_ack", d_ack, e_dack);
    check_eq("mem_oe", mem_oe, e_oe);
    check_eq("mem_st", mem_st, e_st);
    check_eq("mem_addr", mem_addr, m_addr);
    if (!e_oe) check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("i_rdata", i_rdata, m_irdata);
    check_eq("d_rdata", d_rdata, m_drdata);
    if (acking)
      $display("txn cyc=%0d port=%s we=%0b addr=%04h wdata=%04h rdata=%04h",
               cyc, t.port ? "D" : "I", t.we, t.addr, t.wdata,
               t.port ? d_rdata : i_rdata);
  endtask

  task automatic tick();
    model_advance();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int k;
    for (int a = 0; a < 65536; a++) begin
      env_mem[a] = 16'(a * 7) ^ 16'hA5A5;
      ref_mem[a] = 16'(a * 7) ^ 16'hA5A5;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;

    // Single instruction read
    env_mem[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    check_eq("rd_oe", mem_oe, 1);
    check_eq("rd_addr", mem_addr, 16'h0010);
    tick();
    check_eq("rd_ack", i_ack, 1);
    check_eq("rd_data", i_rdata, 16'hBEEF);
    i_req = 1'b0;
    tick();
    check_eq("rd_hold", i_rdata, 16'hBEEF);
    tick();

    // Single data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    tick();
    check_eq("wr_st", mem_st, 1);
    check_eq("wr_oe", mem_oe, 0);
    check_eq("wr_addr", mem_addr, 16'h0200);
    check_eq("wr_wdata", mem_wdata, 16'h1234);
    tick();
    check_eq("wr_ack", d_ack, 1);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_eq("wr_mem", env_mem[16'h0200], 16'h1234);

    // Request dropped after one cycle, inputs scrambled after latch
    i_req = 1'b1; i_addr = 16'h0004;
    tick();
    i_req = 1'b0; i_addr = 16'h0055;
    check_eq("drop_addr", mem_addr, 16'h0004);
    tick();
    check_eq("drop_ack", i_ack, 1);
    for (int n = 0; n < 3; n++) begin
      tick();
      check_eq("drop_noacc", mem_oe | i_ack, 0);
    end

    // Contention from reset release
    reset_pulse();
    i_req = 1'b1; i_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    k = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      check_eq("cont_excl", i_ack & d_ack, 0);
      if (i_ack || d_ack) begin
        check_eq($sformatf("cont_order%0d", k), d_ack, (k % 2 == 0));
        k++;
      end
    end
    check_eq("cont_count", k, 4);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Reset in the middle of a write access
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h5678;
    tick();
    check_eq("abort_st_pre", mem_st, 1);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("abort_st", mem_st, 0);
    check_eq("abort_ack", d_ack, 0);
    check_eq("abort_addr", mem_addr, 0);
    tick();
    check_eq("abort_noack", d_ack, 0);
    reset = 1'b1;
    tick();
    check_eq("replay_st", mem_st, 1);
    check_eq("replay_addr", mem_addr, 16'h0300);
    tick();
    check_eq("replay_ack", d_ack, 1);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_eq("replay_mem", env_mem[16'h0300], 16'h5678);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (i_req && e_iack) begin
        if ($urandom_range(0, 1) == 0) i_req = 1'b0;
        else i_addr = 16'($urandom_range(0, 15));
      end else if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin
          i_req = 1'b1; i_addr = 16'($urandom_range(0, 15));
        end
      end else if (t.valid && !t.port && cyc <= t.acc) begin
        if ($urandom_range(0, 3) == 0) i_req = 1'b0;
        else i_addr = 16'($urandom);
      end
      if (d_req && e_dack) begin
        if ($urandom_range(0, 1) == 0) d_req = 1'b0;
        else begin
          d_we = 1'($urandom); d_addr = 16'($urandom_range(0, 15)); d_wdata = 16'($urandom);
        end
      end else if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom);
          d_addr = 16'($urandom_range(0, 15)); d_wdata = 16'($urandom);
        end
      end else if (t.valid && t.port && cyc <= t.acc) begin
        if ($urandom_range(0, 3) == 0) d_req = 1'b0;
        else begin
          d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
      end
      tick();
      check_eq("rand_st_oe_excl", mem_st & mem_oe, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of both requester ports and memory port.
REQ-002 Parameter DATA_W, default 16, data width of both requester ports and memory port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 i_req  input  1  instruction-fetch read request, held high until i_ack.
REQ-006 i_addr  input  ADDR_W  instruction-fetch address.
REQ-007 i_rdata  output  DATA_W  instruction read data, valid in the i_ack cycle, held until next i_ack.
REQ-008 i_ack  output  1  one-cycle completion pulse for instruction port.
REQ-009 d_req  input  1  data-port request, held high until d_ack.
REQ-010 d_we  input  1  data-port write enable (1 write, 0 read).
REQ-011 d_addr  input  ADDR_W  data-port address.
REQ-012 d_wdata  input  DATA_W  data-port write data.
REQ-013 d_rdata  output  DATA_W  data read data, valid in the d_ack cycle, held until next data read ack.
REQ-014 d_ack  output  1  one-cycle completion pulse for data port (reads and writes).
REQ-015 mem_addr  output  ADDR_W  shared memory address.
REQ-016 mem_wdata  output  DATA_W  shared memory write data.
REQ-017 mem_rdata  input  DATA_W  shared memory read data, valid one cycle after mem_oe.
REQ-018 mem_st  output  1  memory store strobe, one cycle per write.
REQ-019 mem_oe  output  1  memory output enable, one cycle per read.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE; ACCESS always lasts exactly one cycle.
REQ-021 In IDLE or DONE, with an eligible request, the arbiter latches the winner's port id, address, we and wdata and enters ACCESS next cycle; otherwise IDLE.
REQ-022 In ACCESS: mem_addr = latched address; mem_oe=1 for reads, mem_st=1 and mem_wdata = latched wdata for writes; next state DONE.
REQ-023 In DONE: the served port's ack=1 for exactly one cycle; for reads mem_rdata is captured into that port's rdata register in the same edge.
REQ-024 In DONE, the port being acked is not eligible for arbitration; only the other port may win.
REQ-025 Latency: request first sampled high at edge N -> ACCESS in cycle N+1 -> ack in cycle N+2; back-to-back throughput one transaction per 2 cycles.
REQ-026 Fixed priority: d_req beats i_req when both are eligible in the same cycle.
REQ-027 Request inputs changing after latch do not affect the transaction in flight; req dropped before ack is still completed and acked.
REQ-028 mem_st and mem_oe never assert together; both are 0 in IDLE and DONE.
REQ-029 i_ack and d_ack never assert in the same cycle.
REQ-030 mem_addr and mem_wdata hold their last values outside ACCESS.

Reset
REQ-031 While reset is low: state=IDLE, mem_st=0, mem_oe=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, last-grant=instruction.
REQ-032 Reset during ACCESS or DONE aborts the transaction with no ack; first arbitration occurs on the first edge after reset rises.

Configuration
REQ-033 Macro MEM_ARB_RR_EN defined: when both ports are eligible, the port not granted last wins (round-robin); last-grant resets to instruction, so data wins first contention.
REQ-034 MEM_ARB_RR_EN undefined: fixed data-over-instruction priority per REQ-026; last-grant register is not implemented.

Verification
REQ-035 Single read: i_req=1, i_addr=0x0010, memory holds 0xBEEF -> mem_oe=1 with mem_addr=0x0010 at N+1, i_ack=1 and i_rdata=0xBEEF at N+2.
REQ-036 Single write: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234 -> mem_st=1, mem_addr=0x0200, mem_wdata=0x1234 at N+1, d_ack at N+2, mem_oe stays 0.
REQ-037 Contention, macro undefined: i_req and d_req held high for 4 transactions -> grant order D,I,D,I; with i_req and d_req both continuously re-requested, D served in every DONE where it is eligible.
REQ-038 Contention, MEM_ARB_RR_EN defined: both held high from reset release -> acks alternate d,i,d,i, never two consecutive acks to one port.
REQ-039 Abort: reset low in ACCESS of a write to 0x0300 -> mem_st drops immediately, no d_ack, state IDLE; after release, d_req still high -> write replays and acks at N+2.
REQ-040 Req drop: i_req high one cycle only, i_addr=0x0004 -> transaction still completes, i_ack at N+2, no second access issued.
